i2c_target_regfile: RTL



---
 rtl/i2c_target_regfile.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regfile
// Purpose  : I2C target responder with a byte-wide register file behind a
//            16-bit auto-incrementing register pointer. Supports burst
//            writes, pointer-only writes and (repeated-start) burst reads.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   scl_in       SCL pad input (asynchronous)
//   sda_in       SDA pad input (asynchronous)
//   sda_oe       1 = pull SDA low (open drain)
//   loc_addr     local read address (low log2(MEM_DEPTH) bits used)
//   loc_rdata    register file data at loc_addr, one cycle latency
//   wr_evt       one-cycle pulse per data byte written over I2C
//   wr_evt_addr  register address of that byte
//   wr_evt_data  byte written
//   busy         high while a transaction addressed to the bus is active
// ============================================================================
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         MEM_DEPTH  = 256,
  parameter int         FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] loc_addr,
  output logic [7:0]  loc_rdata,
  output logic        wr_evt,
  output logic [15:0] wr_evt_addr,
  output logic [7:0]  wr_evt_data,
  output logic        busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] c_flt_max = FW'(FILTER_LEN - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEV_ADDR = 4'd1;
  localparam logic [3:0] S_ACK_DEV  = 4'd2;
  localparam logic [3:0] S_PTR_HI   = 4'd3;
  localparam logic [3:0] S_ACK_HI   = 4'd4;
  localparam logic [3:0] S_PTR_LO   = 4'd5;
  localparam logic [3:0] S_ACK_LO   = 4'd6;
  localparam logic [3:0] S_WR_DATA  = 4'd7;
  localparam logic [3:0] S_ACK_WR   = 4'd8;
  localparam logic [3:0] S_RD_DATA  = 4'd9;
  localparam logic [3:0] S_RD_ACK   = 4'd10;

  // Index 1 = SCL, index 0 = SDA.
  logic [1:0]    w_pad;
  logic [1:0]    r_sync1, r_sync2, r_filt, r_filt_d;
  logic [FW-1:0] r_flt_cnt [2];

  assign w_pad = {scl_in, sda_in};

  // Two-flop synchroniser followed by a level filter: the filtered level only
  // follows the synchronised input after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) r_flt_cnt[i] <= '0;
    end else begin
      r_sync1  <= w_pad;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_flt_cnt[i] <= '0;
        end else if (r_flt_cnt[i] == c_flt_max) begin
          r_filt[i]    <= r_sync2[i];
          r_flt_cnt[i] <= '0;
        end else begin
          r_flt_cnt[i] <= r_flt_cnt[i] + FW'(1);
        end
      end
    end
  end

  logic w_scl, w_sda, w_scl_d, w_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl      = r_filt[1];
  assign w_sda      = r_filt[0];
  assign w_scl_d    = r_filt_d[1];
  assign w_sda_d    = r_filt_d[0];
  assign w_scl_rise = w_scl & ~w_scl_d;
  assign w_scl_fall = ~w_scl & w_scl_d;
  // SCL must be high on both samples so an SCL edge is never mistaken for a condition.
  assign w_start    = w_scl & w_scl_d & ~w_sda & w_sda_d;
  assign w_stop     = w_scl & w_scl_d & w_sda & ~w_sda_d;

  logic [3:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [15:0] r_ptr;
  logic        r_rw;
  logic        r_ack_on;
  logic [7:0]  w_byte;
  logic [7:0]  w_mem_rd;
  logic        w_mem_we;
  logic [7:0]  mem [MEM_DEPTH];

  assign w_byte   = {r_shift[6:0], w_sda};
  assign w_mem_rd = mem[r_ptr[AW-1:0]];
  assign w_mem_we = !rst && !w_start && !w_stop && (r_state == S_WR_DATA)
                    && w_scl_rise && (r_bit_cnt == 3'd7);
  assign busy     = (r_state != S_IDLE);

  // Register file: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[r_ptr[AW-1:0]] <= w_byte;
  end

  // Reading before the write commits returns the old byte on a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) loc_rdata <= 8'h00;
    else     loc_rdata <= mem[loc_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_ptr       <= 16'h0000;
      r_rw        <= 1'b0;
      r_ack_on    <= 1'b0;
      sda_oe      <= 1'b0;
      wr_evt      <= 1'b0;
      wr_evt_addr <= 16'h0000;
      wr_evt_data <= 8'h00;
    end else begin
      wr_evt <= 1'b0;
      if (w_start) begin
        r_state   <= S_DEV_ADDR;
        r_bit_cnt <= 3'd0;
        r_ack_on  <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_ack_on <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        case (r_state)
          S_DEV_ADDR, S_PTR_HI, S_PTR_LO, S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (r_state)
                  S_DEV_ADDR: begin
                    if (w_byte[7:1] == DEV_ADDR) begin
                      r_rw    <= w_byte[0];
                      r_state <= S_ACK_DEV;
                      // Preload the first read byte so it is ready when the ACK ends.
                      if (w_byte[0]) r_shift <= w_mem_rd;
                    end else begin
                      r_state <= S_IDLE;
                    end
                  end
                  S_PTR_HI: begin
                    r_ptr[15:8] <= w_byte;
                    r_state     <= S_ACK_HI;
                  end
                  S_PTR_LO: begin
                    r_ptr[7:0] <= w_byte;
                    r_state    <= S_ACK_LO;
                  end
                  default: begin
                    wr_evt      <= 1'b1;
                    wr_evt_addr <= r_ptr;
                    wr_evt_data <= w_byte;
                    r_ptr       <= r_ptr + 16'd1;
                    r_state     <= S_ACK_WR;
                  end
                endcase
              end
            end
          end

          // First SCL fall after the byte pulls SDA low; the next fall ends the ACK.
          S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_ack_on <= 1'b1;
                sda_oe   <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_bit_cnt <= 3'd0;
                sda_oe    <= 1'b0;
                case (r_state)
                  S_ACK_DEV: begin
                    if (r_rw) begin
                      r_state <= S_RD_DATA;
                      sda_oe  <= ~r_shift[7];
                    end else begin
                      r_state <= S_PTR_HI;
                    end
                  end
                  S_ACK_HI: r_state <= S_PTR_LO;
                  default:  r_state <= S_WR_DATA;
                endcase
              end
            end
          end

          // bit_cnt counts bits already sampled by the master; with a count of
          // zero the MSB has not yet been put on the bus (entry after master ACK).
          S_RD_DATA: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd0) begin
                sda_oe <= ~r_shift[7];
              end else begin
                r_shift <= {r_shift[6:0], 1'b0};
                sda_oe  <= ~r_shift[6];
              end
            end
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_ptr   <= r_ptr + 16'd1;
                r_state <= S_RD_ACK;
              end
            end
          end

          S_RD_ACK: begin
            if (w_scl_fall) sda_oe <= 1'b0;
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_shift   <= w_mem_rd;
                r_bit_cnt <= 3'd0;
                r_state   <= S_RD_DATA;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  logic unused_loc_bits;
  assign unused_loc_bits = ^loc_addr[15:AW];

endmodule
`default_nettype wire
